// File: rtl/fns_dec_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fns_dec_iter
//  Description : Iterative Fibonacci-numeral-system decoder for the CAC
//                receive path. Consumes BPC codeword bits per cycle and
//                generates the Fibonacci weights on the fly. Flags forbidden
//                3C patterns. Valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module fns_dec_iter #(
    parameter int CW        = 42,
    parameter int BPC       = 1,
    parameter int DW        = 30,
    parameter int FPF_CHECK = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] codein,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          fpf_err
);

    // Fibonacci number F(n) with F(0)=0, F(1)=1, used only at elaboration
    function automatic longint unsigned fib(input int n);
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        a = 64'd0;
        b = 64'd1;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    localparam longint unsigned c_FMAX  = fib(CW + 2) - 64'd1;
    localparam int              c_STEPS = CW / BPC;
    localparam int              c_SW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_SW-1:0] c_LAST  = c_SW'(c_STEPS - 1);

    // Parameter sanity: the codeword must split into whole BPC chunks and
    // the largest decodable value must fit in DW bits.
    if ((BPC < 1) || (BPC > CW) || ((CW % BPC) != 0)) begin : g_bad_bpc
        $error("fns_dec_iter: CW must be a multiple of BPC with 1 <= BPC <= CW");
    end
    if ((DW < 63) && ((64'd1 << DW) <= c_FMAX)) begin : g_bad_dw
        $error("fns_dec_iter: DW too small for the largest codeword value");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_busy;
    logic            w_last;

    logic [CW-1:0]   r_sh;
    logic [DW-1:0]   r_acc;
    logic [DW:0]     r_p;
    logic [DW:0]     r_q;
    logic [c_SW-1:0] r_step;
    logic            r_err;
    logic [DW-1:0]   r_dataout;
    logic            r_fpf;

    logic [DW:0]     w_wt [0:BPC];
    logic [DW-1:0]   w_acc_next;
    logic            w_fpf;

    // Forbidden-pattern detect; the lines beside the codeword are treated as
    // grounded, so a lone 1 at either edge also counts as "010".
    if (FPF_CHECK != 0) begin : g_fpf
        logic [CW+1:0] w_pad;
        assign w_pad = {1'b0, codein, 1'b0};
        always_comb begin
            w_fpf = 1'b0;
            for (int i = 0; i < CW; i++) begin
                if ((w_pad[i +: 3] == 3'b010) || (w_pad[i +: 3] == 3'b101)) begin
                    w_fpf = 1'b1;
                end
            end
        end
    end else begin : g_no_fpf
        assign w_fpf = 1'b0;
    end

    // Weights for this cycle's BPC bits (plus one extra for the next q) and
    // the accumulate of the bits currently at the bottom of the shifter
    always_comb begin
        w_wt[0] = r_q;
        w_wt[1] = r_p + r_q;
        for (int j = 2; j <= BPC; j++) begin
            w_wt[j] = w_wt[j-1] + w_wt[j-2];
        end
        w_acc_next = r_acc;
        for (int j = 0; j < BPC; j++) begin
            if (r_sh[j]) begin
                w_acc_next = w_acc_next + w_wt[j][DW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (r_step == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, accumulate/advance while busy, publish result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh      <= '0;
            r_acc     <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_step    <= '0;
            r_err     <= 1'b0;
            r_dataout <= '0;
            r_fpf     <= 1'b0;
        end else if (w_accept) begin
            r_sh   <= codein;
            r_acc  <= '0;
            r_p    <= '0;
            r_q    <= (DW+1)'(1);
            r_step <= '0;
            r_err  <= w_fpf;
        end else if (w_busy) begin
            r_acc  <= w_acc_next;
            r_p    <= w_wt[BPC-1];
            r_q    <= w_wt[BPC];
            r_sh   <= r_sh >> BPC;
            r_step <= r_step + c_SW'(1);
            if (w_last) begin
                r_dataout <= w_acc_next;
                r_fpf     <= r_err;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign dataout   = r_dataout;
    assign fpf_err   = r_fpf;

endmodule
`default_nettype wire

// File: tb/tb_fns_dec_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fns_dec_iter
//  Description : Directed self-checking bench for fns_dec_iter. Three builds
//                share one stimulus: BPC=1 (main), BPC=3, and BPC=42 with
//                the pattern check disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fns_dec_iter;

    localparam int CW = 42;
    localparam int DW = 30;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [CW-1:0] codein;
    logic          out_ready;

    logic          in_ready_a, out_valid_a, fpf_a;
    logic [DW-1:0] dataout_a;
    logic          in_ready_b, out_valid_b, fpf_b;
    logic [DW-1:0] dataout_b;
    logic          in_ready_c, out_valid_c, fpf_c;
    logic [DW-1:0] dataout_c;

    int total;
    int bad;

    fns_dec_iter #(.CW(CW), .BPC(1), .DW(DW), .FPF_CHECK(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .codein(codein), .out_valid(out_valid_a), .out_ready(out_ready),
        .dataout(dataout_a), .fpf_err(fpf_a)
    );

    fns_dec_iter #(.CW(CW), .BPC(3), .DW(DW), .FPF_CHECK(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .codein(codein), .out_valid(out_valid_b), .out_ready(out_ready),
        .dataout(dataout_b), .fpf_err(fpf_b)
    );

    fns_dec_iter #(.CW(CW), .BPC(CW), .DW(DW), .FPF_CHECK(0)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .codein(codein), .out_valid(out_valid_c), .out_ready(out_ready),
        .dataout(dataout_c), .fpf_err(fpf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one word, measure latency of each build, check results
    task automatic send_word(input string tag, input logic [CW-1:0] cw,
                             input logic [DW-1:0] exp_d, input logic exp_f);
        int la;
        int lb;
        int lc;
        la = 0;
        lb = 0;
        lc = 0;
        codein   = cw;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, in_ready_a, 1'b0);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (out_valid_b && lb == 0) lb = n;
            if (out_valid_c && lc == 0) lc = n;
            if (out_valid_a) begin
                la = n;
                break;
            end
        end
        chk({tag, "_lat_bpc1"},  la, 42);
        chk({tag, "_lat_bpc3"},  lb, 14);
        chk({tag, "_lat_bpc42"}, lc, 1);
        chk({tag, "_data_bpc1"},  dataout_a, exp_d);
        chk({tag, "_data_bpc3"},  dataout_b, exp_d);
        chk({tag, "_data_bpc42"}, dataout_c, exp_d);
        chk({tag, "_fpf_bpc1"},   fpf_a, exp_f);
        chk({tag, "_fpf_bpc3"},   fpf_b, exp_f);
        chk({tag, "_fpf_nochk"},  fpf_c, 1'b0);
    endtask

    // One-cycle out_ready pulse; every build must drop back to idle
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_clr"},   out_valid_a, 1'b0);
        chk({tag, "_ir_a"},     in_ready_a, 1'b1);
        chk({tag, "_ir_b"},     in_ready_b, 1'b1);
        chk({tag, "_ir_c"},     in_ready_c, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        codein    = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready_a,  1'b1);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_dataout",   dataout_a,   '0);
        chk("rst_fpf",       fpf_a,       1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready_a, 1'b1);

        // Single-bit and zero words
        send_word("zero", 42'd0, 30'd0, 1'b0);
        release_out("zero");
        send_word("bit0", 42'd1, 30'd1, 1'b1);
        release_out("bit0");
        send_word("bit1", 42'd2, 30'd1, 1'b1);
        release_out("bit1");
        send_word("bit2", 42'd4, 30'd2, 1'b1);
        release_out("bit2");
        send_word("bit3", 42'd8, 30'd3, 1'b1);
        release_out("bit3");
        send_word("bit41", 42'h200_0000_0000, 30'd267914296, 1'b1);
        release_out("bit41");

        // Full-scale and mixed patterns
        send_word("ones", 42'h3FF_FFFF_FFFF, 30'd701408732, 1'b0);
        release_out("ones");
        send_word("w101", 42'b101, 30'd3, 1'b1);
        release_out("w101");
        send_word("w110011", 42'b110011, 30'd15, 1'b0);

        // Backpressure: hold the result, ignore a pulsed new word
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                codein   = 42'd1;
                in_valid = 1'b1;
            end
            if (k == 3) in_valid = 1'b0;
            chk("bp_out_valid", out_valid_a, 1'b1);
            chk("bp_dataout",   dataout_a,   30'd15);
            chk("bp_fpf",       fpf_a,       1'b0);
            chk("bp_in_ready",  in_ready_a,  1'b0);
        end
        release_out("bp");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_no_capture_ov", out_valid_a, 1'b0);
            chk("bp_no_capture_ir", in_ready_a,  1'b1);
        end

        // Reset while busy at step 20
        codein   = 42'h3FF_FFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid_a, 1'b0);
        chk("midrst_dataout",   dataout_a,   '0);
        chk("midrst_fpf",       fpf_a,       1'b0);
        chk("midrst_ov_done",   out_valid_c, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready_a, 1'b1);
        send_word("after_rst", 42'd1, 30'd1, 1'b1);
        release_out("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fns_dec_iter.md
Name: fns_dec_iter

Overview:
Parametrised, multi-cycle Fibonacci-numeral-system (FNS) decoder for the CAC receive path. It converts a CW-bit crosstalk-avoidance codeword to its binary value by accumulating BPC weighted bits per cycle, generating the Fibonacci weights on the fly instead of from a fixed constant table. It also flags forbidden 3C patterns, and uses valid/ready handshakes on input and output so it can sit between the bus receiver and the data sink.

Parameters:
CW, 42, codeword width in bits; must be a multiple of BPC.
BPC, 1, codeword bits consumed per cycle (1..CW).
DW, 30, output width; elaboration error if 2^DW <= F(CW+2)-1.
FPF_CHECK, 1, 1 = enable forbidden-pattern check; 0 = fpf_err tied 0.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  codein is valid.
in_ready  out  1  block can accept a codeword.
codein  in  CW  codeword; bit i has weight F(i+1), with F(1)=F(2)=1.
out_valid  out  1  dataout and fpf_err are valid.
out_ready  in  1  sink accepts the result.
dataout  out  DW  decoded value, sum of codein[i]*F(i+1).
fpf_err  out  1  codeword contained "010" or "101" in some bits [i+2:i].

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; in_ready=1; out_valid=0; dataout=0; fpf_err=0; accumulator, shift register, weight registers and step counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: latch codein into the shift register, set acc=0, p=F(0)=0, q=F(1)=1, step=0.
  - In the same cycle, if FPF_CHECK=1, register the combinational pattern check of codein into err. Go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, for j=0..BPC-1, acc += sh[j]*w_j, where w_0=q, w_1=p+q, and w_j=w_(j-1)+w_(j-2).
  - Then advance (p,q) by BPC Fibonacci steps, shift sh right by BPC, and increment step.
  - When step reaches CW/BPC-1, the accumulate is the final one: load dataout=acc_next and fpf_err=err, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; dataout and fpf_err are held stable while out_ready=0.
  - in_valid is ignored in this state.
  - On out_ready=1: clear out_valid, go to IDLE; in_ready=1 on the following cycle. There is no same-cycle accept in DONE.
- Latency: out_valid rises CW/BPC clock edges after the accept edge. Throughput is one word per CW/BPC+2 cycles when out_ready is tied high.
- Width rules:
  - p and q are DW+1 bits, so the final advance cannot wrap.
  - acc is DW bits; the DW sizing check guarantees no overflow.
- fpf_err is informational only: decoding of the word still completes with the arithmetic value.
- in_valid held while in_ready=0 has no effect; the source must hold codein until accepted.
- Reset asserted in BUSY or DONE aborts the word: no out_valid pulse, all state cleared.

Test Plan:
1. CW=42, BPC=1. Send codein=0, then codein=1 (bit0), then bit1 only, then bit2 only -> dataout = 0, 1, 1, 2. For each word, fpf_err=0 for the zero word and 1 for the three single-bit words (each contains a "010" or "001"/"100"-bounded "010" at the edge triplet). out_valid must rise exactly 42 edges after each accept.
2. codein=all ones (42'h3FF_FFFF_FFFF) -> dataout=701408732, fpf_err=0. Then codein=42'b101 -> dataout=3, fpf_err=1. Then codein=42'b110011 -> dataout=1+1+5+8=15, fpf_err=0.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dataout and fpf_err stable, in_ready=0, and a pulsed in_valid with a new word is not captured. Release out_ready -> in_ready=1 one cycle later.
4. Reset mid-BUSY: assert rst at step 20 -> out_valid, dataout and fpf_err are 0 immediately, in_ready=1 after release, and the next word (codein=1) decodes to 1.
5. BPC=3 build: repeat scenarios 1 and 2 -> identical values, out_valid 14 edges after accept. BPC=42 -> out_valid 1 edge after accept.
6. FPF_CHECK=0 build: codein=42'b101 -> dataout=3, fpf_err=0.
